// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte requesters using round-robin
// arbitration, with a per-requester lock that keeps multi-byte messages together.
//   state     | meaning
//   IDLE      | no owner; wait for UART idle and any request
//   ISSUE     | pulse write strobe and ack for the latched byte
//   WAIT_BUSY | wait for UART to report busy, watchdog counting
//   WAIT_DONE | frame in flight; wait for busy to fall
//   RELEASE   | keep owner if locked and requesting, else return to IDLE
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     lock_i,
  input  logic [N*8-1:0]   dat_i,
  output logic [N-1:0]     ack_o,
  output logic [N-1:0]     grant_o,
  output logic             uart_wr_o,
  output logic [7:0]       uart_dat_o,
  input  logic             uart_tx_busy_i,
  output logic             err_o
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [7:0]    byte_q, byte_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_d, ack_d;
  logic          wr_d, err_d;
  logic [7:0]    dat_d;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;

  // First requester after the last released owner, wrapping around.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int o = 1; o <= N; o++) begin
      cand = IW'((int'(ptr_q) + o) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    grant_d = grant_o;
    ack_d   = '0;
    wr_d    = 1'b0;
    dat_d   = uart_dat_o;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!uart_tx_busy_i && found) begin
          gidx_d        = pick;
          byte_d        = dat_i[{pick, 3'b000} +: 8];
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        wr_d    = 1'b1;
        dat_d   = byte_q;
        ack_d   = grant_o;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMAX) begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy_i) state_d = RELEASE;
      end
      RELEASE: begin
        if (lock_i[gidx_q] && req_i[gidx_q]) begin
          byte_d  = dat_i[{gidx_q, 3'b000} +: 8];
          state_d = ISSUE;
        end else begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N - 1);
      gidx_q     <= '0;
      byte_q     <= 8'h00;
      cnt_q      <= '0;
      grant_o    <= '0;
      ack_o      <= '0;
      uart_wr_o  <= 1'b0;
      uart_dat_o <= 8'h00;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      grant_o    <= grant_d;
      ack_o      <= ack_d;
      uart_wr_o  <= wr_d;
      uart_dat_o <= dat_d;
      err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a UART busy model drive the
// design; a transaction-level round-robin/lock model predicts every strobe.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N-1:0]   lock_i;
  logic [N*8-1:0] dat_i;
  logic [N-1:0]   ack_o;
  logic [N-1:0]   grant_o;
  logic           uart_wr_o;
  logic [7:0]     uart_dat_o;
  logic           uart_tx_busy_i;
  logic           err_o;

  uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .dat_i(dat_i),
    .ack_o(ack_o), .grant_o(grant_o), .uart_wr_o(uart_wr_o),
    .uart_dat_o(uart_dat_o), .uart_tx_busy_i(uart_tx_busy_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-requester byte storage: bit 8 = message continues (lock).
  logic [8:0]   sbuf [N][256];
  int           shead [N];
  int           stail [N];
  int           mhead [N];
  logic [N-1:0] lockr;

  // Reference model state.
  int   mlast;
  logic mlocked;
  int   mowner;

  // UART model and timing observation.
  int   umode;        // 0 normal, 1 never busy, 2 forced busy
  int   busy_len;
  bit   rand_busy;
  int   busy_cnt;
  bit   pending_wr;
  logic last_sampled;
  int   cyc, fall_cyc, wr_cyc, err_cyc, gclr_cyc;
  int   nstrobes, nerr;
  logic [N-1:0] prev_grant;
  logic [7:0] seq_log [$];
  int         gap_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_i[i]       = (shead[i] < stail[i]);
      dat_i[8*i +: 8] = (shead[i] < stail[i]) ? sbuf[i][shead[i]][7:0] : 8'h00;
      lock_i[i]      = lockr[i];
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic more);
    sbuf[i][stail[i]] = {more, b};
    stail[i]++;
    drive_reqs();
  endtask

  function automatic int model_pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += stail[i] - mhead[i];
    return s;
  endfunction

  task automatic check_strobe();
    int e, c;
    logic found;
    logic [8:0] ent;
    e = 0;
    found = 1'b0;
    if (mlocked) begin
      e = mowner;
      found = (mhead[e] < stail[e]);
    end else begin
      for (int o = 1; o <= N; o++) begin
        c = (mlast + o) % N;
        if (!found && mhead[c] < stail[c]) begin
          found = 1'b1;
          e = c;
        end
      end
    end
    chk("strobe_expected", {31'd0, found}, 32'd1);
    if (found) begin
      ent = sbuf[e][mhead[e]];
      mhead[e]++;
      chk("strobe_grant", {28'd0, grant_o}, 32'd1 << e);
      chk("strobe_ack", {28'd0, ack_o}, 32'd1 << e);
      chk("strobe_byte", {24'd0, uart_dat_o}, {24'd0, ent[7:0]});
      gap_log.push_back(cyc - fall_cyc);
      if (ent[8]) begin
        mlocked = 1'b1;
        mowner = e;
      end else begin
        mlocked = 1'b0;
        mlast = e;
      end
    end
    chk("strobe_uart_idle", {31'd0, uart_tx_busy_i}, 32'd0);
    seq_log.push_back(uart_dat_o);
  endtask

  task automatic step();
    logic sampled;
    @(posedge clk);
    #1;
    cyc++;
    sampled = uart_tx_busy_i;
    if (last_sampled && !sampled) fall_cyc = cyc;
    last_sampled = sampled;
    if (pending_wr) begin
      if (umode == 0) busy_cnt = rand_busy ? int'($urandom_range(6, 1)) : busy_len;
      pending_wr = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_tx_busy_i = (umode == 2) || (busy_cnt > 0);
    if (uart_wr_o === 1'b1) begin
      pending_wr = 1'b1;
      wr_cyc = cyc;
      nstrobes++;
      check_strobe();
    end
    if (err_o === 1'b1) begin
      err_cyc = cyc;
      nerr++;
    end
    if (prev_grant != '0 && grant_o == '0) gclr_cyc = cyc;
    prev_grant = grant_o;
    for (int i = 0; i < N; i++) begin
      if (ack_o[i] === 1'b1 && shead[i] < stail[i]) begin
        lockr[i] = sbuf[i][shead[i]][8];
        shead[i]++;
      end
    end
    drive_reqs();
  endtask

  task automatic model_reset();
    mlast = N - 1;
    mlocked = 1'b0;
    mowner = 0;
    lockr = '0;
    for (int i = 0; i < N; i++) begin
      shead[i] = stail[i];
      mhead[i] = stail[i];
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int n0 = nstrobes;
    for (int n = 0; n < budget && nstrobes == n0; n++) step();
    chk(tag, nstrobes - n0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = (grant_o === '0) && (model_pending() == 0) &&
             (uart_tx_busy_i === 1'b0) && (busy_cnt == 0);
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int p, s0, g0, e0, n0, pushed, nm, len;
    rst = 1'b0; req_i = '0; lock_i = '0; dat_i = '0; uart_tx_busy_i = 1'b0;
    umode = 0; busy_len = 20; rand_busy = 1'b0; busy_cnt = 0; pending_wr = 1'b0;
    last_sampled = 1'b0; cyc = 0; fall_cyc = 0; wr_cyc = -1; err_cyc = -1;
    gclr_cyc = -1; nstrobes = 0; nerr = 0; prev_grant = '0;
    for (int i = 0; i < N; i++) begin shead[i] = 0; stail[i] = 0; mhead[i] = 0; end
    model_reset();

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_grant", {28'd0, grant_o}, 32'd0);
    chk("rst_ack", {28'd0, ack_o}, 32'd0);
    chk("rst_wr", {31'd0, uart_wr_o}, 32'd0);
    chk("rst_dat", {24'd0, uart_dat_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Single request, busy for 20 cycles
    busy_len = 20;
    push(0, 8'hFF, 1'b0);
    p = cyc;
    step();
    chk("t1_grant", {28'd0, grant_o}, 32'd1);
    step();
    chk("t1_latency", wr_cyc - p, 2);
    wait_idle("t1_idle", 100);
    chk("t1_byte", {24'd0, seq_log[seq_log.size()-1]}, 32'hFF);
    chk("t1_grant_clear", gclr_cyc - fall_cyc, 1);

    // Round-robin with all four requesting
    do_reset();
    busy_len = 5;
    s0 = seq_log.size();
    g0 = gap_log.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b0);
    wait_idle("t2_idle", 400);
    chk("t2_count", seq_log.size() - s0, 8);
    for (int j = 0; j < 8 && s0 + j < seq_log.size(); j++)
      chk("t2_order", {24'd0, seq_log[s0+j]}, {24'd0, 8'h10 + 8'(j % 4)});
    for (int j = 1; j < 8 && g0 + j < gap_log.size(); j++)
      chk("t2_handover_gap", gap_log[g0+j], 3);

    // Lock: requester 2 sends AA,55 locked while requester 0 waits
    push(1, 8'h21, 1'b0);
    wait_idle("t3_pre_idle", 100);
    s0 = seq_log.size();
    g0 = gap_log.size();
    push(0, 8'h01, 1'b0);
    push(2, 8'hAA, 1'b1);
    push(2, 8'h55, 1'b0);
    wait_idle("t3_idle", 400);
    chk("t3_count", seq_log.size() - s0, 3);
    if (seq_log.size() - s0 == 3) begin
      chk("t3_first", {24'd0, seq_log[s0]}, 32'hAA);
      chk("t3_second", {24'd0, seq_log[s0+1]}, 32'h55);
      chk("t3_third", {24'd0, seq_log[s0+2]}, 32'h01);
      chk("t3_lock_gap", gap_log[g0+1], 2);
      chk("t3_unlock_gap", gap_log[g0+2], 3);
    end

    // Busy timeout: UART never reports busy
    umode = 1;
    e0 = nerr;
    push(3, 8'h3C, 1'b0);
    wait_wr("t4_strobe", 20);
    for (int n = 0; n < 40 && nerr == e0; n++) step();
    chk("t4_err_seen", nerr - e0, 1);
    chk("t4_err_latency", err_cyc - wr_cyc, T);
    step();
    chk("t4_err_pulse", {31'd0, err_o}, 32'd0);
    chk("t4_grant_released", {28'd0, grant_o}, 32'd0);
    umode = 0;
    busy_len = 4;
    push(2, 8'h5A, 1'b0);
    wait_idle("t4_idle", 100);
    chk("t4_next_served", {24'd0, seq_log[seq_log.size()-1]}, 32'h5A);

    // Reset during WAIT_DONE
    busy_len = 30;
    push(1, 8'h77, 1'b0);
    wait_wr("t5_strobe", 20);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("t5_grant", {28'd0, grant_o}, 32'd0);
    chk("t5_ack", {28'd0, ack_o}, 32'd0);
    chk("t5_wr", {31'd0, uart_wr_o}, 32'd0);
    chk("t5_dat", {24'd0, uart_dat_o}, 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    s0 = seq_log.size();
    push(1, 8'hB1, 1'b0);
    push(3, 8'hB3, 1'b0);
    wait_idle("t5_idle", 300);
    chk("t5_count", seq_log.size() - s0, 2);
    if (seq_log.size() - s0 == 2) begin
      chk("t5_first", {24'd0, seq_log[s0]}, 32'hB1);
      chk("t5_second", {24'd0, seq_log[s0+1]}, 32'hB3);
    end

    // UART busy when the request arrives
    umode = 2;
    busy_len = 6;
    step();
    push(2, 8'hC2, 1'b0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("t6_no_grant", {28'd0, grant_o}, 32'd0);
    end
    umode = 0;
    wait_wr("t6_strobe", 20);
    chk("t6_latency", wr_cyc - fall_cyc, 1);
    wait_idle("t6_idle", 100);

    // Randomized messages against the reference model
    rand_busy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      n0 = nstrobes;
      pushed = 0;
      for (int i = 0; i < N; i++) begin
        nm = int'($urandom_range(2, 0));
        for (int m = 0; m < nm; m++) begin
          len = int'($urandom_range(3, 1));
          for (int b = 0; b < len; b++) begin
            push(i, 8'($urandom_range(255, 0)), (b < len - 1));
            pushed++;
          end
        end
      end
      wait_idle("rand_idle", 2000);
      chk("rand_count", nstrobes - n0, pushed);
    end
    chk("err_total", nerr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
